// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared types and constants for the NPC AXI4 N-to-1 arbiter.
package ysyx_24100006_axi_pkg;

  typedef enum logic { R_IDLE, R_BUSY } rd_state_t;
  typedef enum logic { W_IDLE, W_BUSY } wr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int ARB_MAX_MASTERS = 8;

endpackage

// File: rtl/ysyx_24100006_arb_pick.sv
// Winner selection for one channel. YSYX_24100006_ARB_RR_EN selects round-robin
// starting after ptr; otherwise fixed priority with the lowest index winning.
module ysyx_24100006_arb_pick #(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
`ifdef YSYX_24100006_ARB_RR_EN
  input  logic [IDX_W-1:0]       ptr,
`endif
  input  logic                   en,
  output logic [NUM_MASTERS-1:0] gnt_oh,
  output logic [IDX_W-1:0]       gnt_idx
);

  always_comb begin
    logic        found;
    int unsigned pos;
    found   = 1'b0;
    pos     = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    if (en) begin
`ifdef YSYX_24100006_ARB_RR_EN
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
        pos = (32'(ptr) + k) % 32'(NUM_MASTERS);
`else
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        pos = k;
`endif
        if (!found && req[pos]) begin
          found       = 1'b1;
          gnt_oh[pos] = 1'b1;
          gnt_idx     = IDX_W'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_24100006_axi_arbiter_n.sv
// N-master to 1-slave AXI4 arbiter; read and write arbitrated independently,
// grant held per burst. Arbitration policy selected by YSYX_24100006_ARB_RR_EN.
module ysyx_24100006_axi_arbiter_n
  import ysyx_24100006_axi_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  localparam int IDX_W       = $clog2(NUM_MASTERS),
  localparam int STRB_W      = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  output logic [NUM_MASTERS-1:0]        m_arready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]      m_arlen,
  input  logic [NUM_MASTERS*3-1:0]      m_arsize,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic                          m_rlast,
  input  logic [NUM_MASTERS-1:0]        m_awvalid,
  output logic [NUM_MASTERS-1:0]        m_awready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]      m_awlen,
  input  logic [NUM_MASTERS*3-1:0]      m_awsize,
  input  logic [NUM_MASTERS-1:0]        m_wvalid,
  output logic [NUM_MASTERS-1:0]        m_wready,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]        m_wlast,
  output logic [NUM_MASTERS-1:0]        m_bvalid,
  input  logic [NUM_MASTERS-1:0]        m_bready,
  output logic [1:0]                    m_bresp,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic [7:0]                    s_arlen,
  output logic [2:0]                    s_arsize,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rlast,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic [7:0]                    s_awlen,
  output logic [2:0]                    s_awsize,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  output logic                          s_wlast,
  input  logic                          s_bvalid,
  output logic                          s_bready,
  input  logic [1:0]                    s_bresp
);

  rd_state_t               rd_state, rd_state_nxt;
  wr_state_t               wr_state, wr_state_nxt;
  logic [IDX_W-1:0]        rd_gnt, wr_gnt, rd_pick_idx, wr_pick_idx;
  logic [NUM_MASTERS-1:0]  rd_pick_oh, wr_pick_oh;
  logic                    rd_gnt_vld, wr_gnt_vld, ar_done, aw_done;
  logic                    rd_release, wr_release;

  assign rd_gnt_vld = (rd_state == R_BUSY);
  assign wr_gnt_vld = (wr_state == W_BUSY);
  assign rd_release = s_rvalid & s_rready & s_rlast;
  assign wr_release = s_bvalid & s_bready;

`ifdef YSYX_24100006_ARB_RR_EN
  logic [IDX_W-1:0] rd_ptr, wr_ptr;
`endif

  ysyx_24100006_arb_pick #(.NUM_MASTERS(NUM_MASTERS)) u_rd_pick (
    .req    (m_arvalid),
`ifdef YSYX_24100006_ARB_RR_EN
    .ptr    (rd_ptr),
`endif
    .en     (rd_state == R_IDLE),
    .gnt_oh (rd_pick_oh),
    .gnt_idx(rd_pick_idx)
  );

  ysyx_24100006_arb_pick #(.NUM_MASTERS(NUM_MASTERS)) u_wr_pick (
    .req    (m_awvalid),
`ifdef YSYX_24100006_ARB_RR_EN
    .ptr    (wr_ptr),
`endif
    .en     (wr_state == W_IDLE),
    .gnt_oh (wr_pick_oh),
    .gnt_idx(wr_pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rd_gnt   <= '0;
      wr_gnt   <= '0;
      ar_done  <= 1'b0;
      aw_done  <= 1'b0;
`ifdef YSYX_24100006_ARB_RR_EN
      rd_ptr   <= IDX_W'(NUM_MASTERS - 1);
      wr_ptr   <= IDX_W'(NUM_MASTERS - 1);
`endif
    end else begin
      rd_state <= rd_state_nxt;
      wr_state <= wr_state_nxt;
      if (rd_state == R_IDLE && |rd_pick_oh) begin
        rd_gnt <= rd_pick_idx;
`ifdef YSYX_24100006_ARB_RR_EN
        rd_ptr <= rd_pick_idx;
`endif
      end else if (rd_gnt_vld && rd_release) begin
        rd_gnt <= '0;
      end
      if (wr_state == W_IDLE && |wr_pick_oh) begin
        wr_gnt <= wr_pick_idx;
`ifdef YSYX_24100006_ARB_RR_EN
        wr_ptr <= wr_pick_idx;
`endif
      end else if (wr_gnt_vld && wr_release) begin
        wr_gnt <= '0;
      end
      if (rd_state_nxt == R_IDLE)      ar_done <= 1'b0;
      else if (s_arvalid && s_arready) ar_done <= 1'b1;
      if (wr_state_nxt == W_IDLE)      aw_done <= 1'b0;
      else if (s_awvalid && s_awready) aw_done <= 1'b1;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (|rd_pick_oh) rd_state_nxt = R_BUSY;
      R_BUSY:  if (rd_release)  rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (|wr_pick_oh) wr_state_nxt = W_BUSY;
      W_BUSY:  if (wr_release)  wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Everything is gated by the grant so idle outputs sit at their reset values.
  always_comb begin
    s_arvalid = 1'b0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = 1'b0;
    m_arready = '0;   m_rvalid = '0; m_rdata = '0; m_rresp = '0;  m_rlast  = 1'b0;
    if (rd_gnt_vld) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (rd_gnt == IDX_W'(i)) begin
          s_arvalid    = m_arvalid[i] & ~ar_done;
          s_araddr     = m_araddr[i*ADDR_W +: ADDR_W];
          s_arlen      = m_arlen[i*8 +: 8];
          s_arsize     = m_arsize[i*3 +: 3];
          s_rready     = m_rready[i];
          m_arready[i] = s_arready & ~ar_done;
          m_rvalid[i]  = s_rvalid;
        end
      end
      m_rdata = s_rdata;
      m_rresp = s_rresp;
      m_rlast = s_rlast;
    end
  end

  always_comb begin
    s_awvalid = 1'b0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_wvalid  = 1'b0; s_wdata  = '0; s_wstrb = '0; s_wlast  = 1'b0; s_bready = 1'b0;
    m_awready = '0;   m_wready = '0; m_bvalid = '0; m_bresp = '0;
    if (wr_gnt_vld) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (wr_gnt == IDX_W'(i)) begin
          s_awvalid    = m_awvalid[i] & ~aw_done;
          s_awaddr     = m_awaddr[i*ADDR_W +: ADDR_W];
          s_awlen      = m_awlen[i*8 +: 8];
          s_awsize     = m_awsize[i*3 +: 3];
          s_wvalid     = m_wvalid[i];
          s_wdata      = m_wdata[i*DATA_W +: DATA_W];
          s_wstrb      = m_wstrb[i*STRB_W +: STRB_W];
          s_wlast      = m_wlast[i];
          s_bready     = m_bready[i];
          m_awready[i] = s_awready & ~aw_done;
          m_wready[i]  = s_wready;
          m_bvalid[i]  = s_bvalid;
        end
      end
      m_bresp = s_bresp;
    end
  end

  a_ar_held: assert property (@(posedge clk) disable iff (!reset)
    (rd_gnt_vld && !ar_done) |-> m_arvalid[rd_gnt]);
  a_aw_held: assert property (@(posedge clk) disable iff (!reset)
    (wr_gnt_vld && !aw_done) |-> m_awvalid[wr_gnt]);
  a_max_masters: assert property (@(posedge clk) NUM_MASTERS <= ARB_MAX_MASTERS);

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter_n.sv
// Directed bench for the two-master AXI arbiter; expectations adapt to
// YSYX_24100006_ARB_RR_EN where the arbitration policy matters.
module tb_ysyx_24100006_axi_arbiter_n;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [5:0]  m_arsize;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [63:0] m_awaddr, m_wdata;
  logic [15:0] m_awlen;
  logic [5:0]  m_awsize;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp;

  int vectors = 0;
  int miscompares = 0;

  ysyx_24100006_axi_arbiter_n #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_bresp(s_bresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] ctl;
    reset = 1'b0;
    clear_inputs();
    m_arvalid = 2'b11; m_araddr = {32'h0000_0200, 32'h0000_0100};
    m_awvalid = 2'b11; m_awaddr = {32'h0000_0600, 32'h0000_0500};
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rlast = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b11;
    m_rready = 2'b11; m_bready = 2'b11;
    step();
    step();
    ctl = {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
           s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    vectors++;
    if (ctl !== 15'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want %b", ctl, 15'b0);
    end
    vectors++;
    if ({m_rdata, m_rresp, m_rlast, m_bresp, s_araddr, s_awaddr, s_wdata, s_wstrb} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h araddr=%h awaddr=%h want all 0", m_rdata, s_araddr, s_awaddr);
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; s_bvalid = 1'b0;
    reset = 1'b1;
    step();
    vectors++;
    if ({m_arready, s_arvalid, s_araddr} !== {2'b01, 1'b1, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL reset_first_grant: got arready=%b araddr=%h want 01 00000100", m_arready, s_araddr);
    end
  endtask

  task automatic test_rr_bursts();
    logic [31:0] exp_d;
    apply_reset();
    m_arvalid = 2'b11; m_araddr = {32'h0000_0200, 32'h0000_0100};
    m_arlen = {8'd3, 8'd3}; m_arsize = {3'd2, 3'd2};
    m_rready = 2'b11; s_arready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      step();
      vectors++;
      if ({m_arready, s_arvalid, s_araddr, s_arlen} !==
          {(m == 0) ? 2'b01 : 2'b10, 1'b1, (m == 0) ? 32'h100 : 32'h200, 8'd3}) begin
        miscompares++;
        $display("FAIL burst_grant_m%0d: got arready=%b arvalid=%b araddr=%h arlen=%0d",
                 m, m_arready, s_arvalid, s_araddr, s_arlen);
      end
      step();
      m_arvalid[m] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        exp_d = 32'hA000 + 32'(m * 16 + b);
        s_rvalid = 1'b1; s_rdata = exp_d; s_rlast = (b == 3);
        #1;
        vectors++;
        if ({m_rvalid, s_rready, s_arvalid, m_rdata, m_rlast} !==
            {(m == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, exp_d, b == 3}) begin
          miscompares++;
          $display("FAIL burst_m%0d_beat%0d: got rvalid=%b rready=%b arvalid=%b rdata=%h rlast=%b want rdata=%h",
                   m, b, m_rvalid, s_rready, s_arvalid, m_rdata, m_rlast, exp_d);
        end
        step();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0;
      vectors++;
      if ({m_arready, s_arvalid, m_rvalid} !== 5'b0) begin
        miscompares++;
        $display("FAIL burst_bubble_m%0d: got arready=%b arvalid=%b rvalid=%b want 0",
                 m, m_arready, s_arvalid, m_rvalid);
      end
    end
  endtask

  task automatic test_priority();
    logic [1:0] exp_oh;
    apply_reset();
    m_arvalid = 2'b11; m_araddr = {32'h0000_0200, 32'h0000_0100};
    m_rready = 2'b11; s_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef YSYX_24100006_ARB_RR_EN
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_oh = 2'b01;
`endif
      step();
      vectors++;
      if (m_arready !== exp_oh) begin
        miscompares++;
        $display("FAIL priority_round%0d: got arready=%b want %b", k, m_arready, exp_oh);
      end
      step();
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'(k);
      #1;
      vectors++;
      if (m_rvalid !== exp_oh) begin
        miscompares++;
        $display("FAIL priority_rvalid%0d: got %b want %b", k, m_rvalid, exp_oh);
      end
      step();
      s_rvalid = 1'b0; s_rlast = 1'b0;
    end
  endtask

  task automatic test_concurrent();
    apply_reset();
    m_arvalid = 2'b10; m_araddr = {32'h0000_0300, 32'h0};
    m_arlen = {8'd1, 8'd0}; m_rready = 2'b10;
    m_awvalid = 2'b01; m_awaddr = {32'h0, 32'h8000_0010}; m_awlen = '0; m_awsize = {3'd0, 3'd2};
    m_wvalid = 2'b01; m_wdata = {32'h0, 32'hABCD_0000}; m_wstrb = {4'b0000, 4'b1100}; m_wlast = 2'b01;
    m_bready = 2'b01;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    step();
    vectors++;
    if ({s_awvalid, s_awaddr, s_awsize, s_wvalid, s_wdata, s_wstrb, s_wlast, m_awready, m_wready} !==
        {1'b1, 32'h8000_0010, 3'd2, 1'b1, 32'hABCD_0000, 4'b1100, 1'b1, 2'b01, 2'b01}) begin
      miscompares++;
      $display("FAIL conc_write_path: got awaddr=%h wdata=%h wstrb=%b awready=%b wready=%b",
               s_awaddr, s_wdata, s_wstrb, m_awready, m_wready);
    end
    vectors++;
    if ({s_arvalid, s_araddr, s_arlen, m_arready} !== {1'b1, 32'h0000_0300, 8'd1, 2'b10}) begin
      miscompares++;
      $display("FAIL conc_read_addr: got arvalid=%b araddr=%h arlen=%0d arready=%b",
               s_arvalid, s_araddr, s_arlen, m_arready);
    end
    step();
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
    s_rvalid = 1'b1; s_rdata = 32'h1111_0000; s_rlast = 1'b0; s_rresp = 2'b00;
    s_bvalid = 1'b1; s_bresp = 2'b10;
    #1;
    vectors++;
    if ({m_bvalid, s_bready, m_bresp, s_awvalid, m_rvalid, s_rready, m_rdata} !==
        {2'b01, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 32'h1111_0000}) begin
      miscompares++;
      $display("FAIL conc_b_and_beat0: got bvalid=%b bready=%b bresp=%b awvalid=%b rvalid=%b rdata=%h",
               m_bvalid, s_bready, m_bresp, s_awvalid, m_rvalid, m_rdata);
    end
    step();
    s_bvalid = 1'b0; s_rdata = 32'h2222_0000; s_rlast = 1'b1;
    #1;
    vectors++;
    if ({s_bready, m_awready, m_rvalid, m_rdata, m_rlast} !== {1'b0, 2'b00, 2'b10, 32'h2222_0000, 1'b1}) begin
      miscompares++;
      $display("FAIL conc_write_released: got bready=%b awready=%b rvalid=%b rdata=%h rlast=%b",
               s_bready, m_awready, m_rvalid, m_rdata, m_rlast);
    end
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    vectors++;
    if ({m_rvalid, s_rready} !== 3'b0) begin
      miscompares++;
      $display("FAIL conc_read_released: got rvalid=%b rready=%b want 0", m_rvalid, s_rready);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d;
    apply_reset();
    m_arvalid = 2'b11; m_araddr = {32'h0000_0200, 32'h0000_0100}; m_arlen = {8'd3, 8'd3};
    s_arready = 1'b1; m_rready = 2'b01;
    step();
    step();
    m_arvalid[0] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_d = 32'hC0DE_0000 + 32'(b);
      s_rvalid = 1'b1; s_rdata = exp_d; s_rlast = (b == 3);
      if (b == 1) begin
        m_rready = 2'b00;
        for (int c = 0; c < 5; c++) begin
          #1;
          vectors++;
          if ({s_rready, m_rvalid, m_rdata, m_arready} !== {1'b0, 2'b01, exp_d, 2'b00}) begin
            miscompares++;
            $display("FAIL stall_cycle%0d: got rready=%b rvalid=%b rdata=%h arready=%b want rdata=%h",
                     c, s_rready, m_rvalid, m_rdata, m_arready, exp_d);
          end
          step();
        end
        m_rready = 2'b01;
      end
      #1;
      vectors++;
      if ({s_rready, m_rvalid, m_rdata, m_rlast} !== {1'b1, 2'b01, exp_d, b == 3}) begin
        miscompares++;
        $display("FAIL stall_beat%0d: got rready=%b rvalid=%b rdata=%h rlast=%b want rdata=%h",
                 b, s_rready, m_rvalid, m_rdata, m_rlast, exp_d);
      end
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    step();
    vectors++;
    if (m_arready !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_next_grant: got arready=%b want 10", m_arready);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    m_arvalid = 2'b01; m_araddr = {32'h0000_0400, 32'h0000_0100}; m_arlen = {8'd0, 8'd3};
    s_arready = 1'b1; m_rready = 2'b11;
    step();
    step();
    m_arvalid = 2'b00;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1; s_rdata = 32'h5000 + 32'(b); s_rlast = 1'b0;
      step();
    end
    s_rdata = 32'h0000_5002;
    #1;
    vectors++;
    if ({m_rvalid, m_rdata} !== {2'b01, 32'h0000_5002}) begin
      miscompares++;
      $display("FAIL midrst_beat2: got rvalid=%b rdata=%h want 01 00005002", m_rvalid, m_rdata);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({m_rvalid, s_rready, m_rdata, m_arready, s_araddr, s_arvalid} !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: got rvalid=%b rready=%b rdata=%h araddr=%h want all 0",
               m_rvalid, s_rready, m_rdata, s_araddr);
    end
    clear_inputs();
    step();
    reset = 1'b1;
    m_arvalid = 2'b10; m_araddr = {32'h0000_0400, 32'h0000_0100};
    s_arready = 1'b1;
    step();
    vectors++;
    if ({m_arready, s_arvalid, s_araddr} !== {2'b10, 1'b1, 32'h0000_0400}) begin
      miscompares++;
      $display("FAIL midrst_fresh_grant: got arready=%b arvalid=%b araddr=%h want 10 1 00000400",
               m_arready, s_arvalid, s_araddr);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_rr_bursts();
    test_priority();
    test_concurrent();
    test_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_axi_arbiter_n.md
# ysyx_24100006_axi_arbiter_n

Parametrised N-master to 1-slave AXI4 arbiter for the NPC memory path. It sits between the core's bus masters (index 0 = MEMU, index 1 = IFU, further indices for DMA/debug) and the single downstream slave (SRAM/SoC bridge). Read and write channels are arbitrated independently. Each grant is held for a whole burst: reads until the `rlast` beat, writes until the B response.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of masters, 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` strobe bits.
- `IDX_W`, default `$clog2(NUM_MASTERS)`: grant index width (localparam).

Ports (master-side buses are flattened; master i occupies slice i):
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `m_arvalid`/`m_arready` in/out N: per-master AR handshake.
- `m_araddr` in N*ADDR_W; `m_arlen` in N*8; `m_arsize` in N*3.
- `m_rvalid` out N; `m_rready` in N.
- `m_rdata` out DATA_W; `m_rresp` out 2; `m_rlast` out 1: broadcast to all masters, qualified by `m_rvalid[i]`.
- `m_awvalid`/`m_awready` in/out N; `m_awaddr` in N*ADDR_W; `m_awlen` in N*8; `m_awsize` in N*3.
- `m_wvalid`/`m_wready` in/out N; `m_wdata` in N*DATA_W; `m_wstrb` in N*(DATA_W/8); `m_wlast` in N.
- `m_bvalid` out N; `m_bready` in N; `m_bresp` out 2: broadcast.
- `s_ar*`, `s_r*`, `s_aw*`, `s_w*`, `s_b*`: single slave-side AXI4 set, same fields at single-master width, opposite directions.

## Operation
- Read FSM `R_IDLE`/`R_BUSY`, with registered `rd_gnt` (IDX_W) and `rd_gnt_vld`.
  - `R_IDLE`: if any `m_arvalid`, choose a winner, load `rd_gnt`, go to `R_BUSY`.
  - `R_BUSY`: route the AR/R fields of master `rd_gnt` to the slave and back. Go to `R_IDLE` on `s_rvalid & s_rready & s_rlast`.
  - In `R_BUSY`, AR fields pass through ungated. A second AR from the granted master after its AR handshake is blocked: `m_arready` is 0 once `ar_done` is set. `ar_done` is cleared on release.
- Write FSM `W_IDLE`/`W_BUSY`, with `wr_gnt`, works the same way.
  - AW and W of the granted master pass straight through.
  - Release on `s_bvalid & s_bready`. `aw_done` blocks a second AW.
- Non-granted masters see `*ready`=0 and `*valid`=0. Slave sees `s_arvalid`/`s_awvalid`/`s_wvalid`=0 and `s_rready`/`s_bready`=0 when idle.
- W data is passed unmodified. Masters supply lane-aligned data per `wstrb`; there is no shifting in this block.
- Read and write may be granted to the same or different masters concurrently.
- Reset mid-burst: all state goes to IDLE, grants clear, and all outputs return to reset values immediately (asynchronous). The slave must be reset together with the arbiter.

## Timing
- Reset values: every `m_*ready`, `m_*valid`, `s_*valid`, `s_*ready` = 0. `m_rdata`, `m_rresp`, `m_rlast`, `m_bresp`, and all slave address/data fields = 0.
- Arbitration latency: a request first seen in cycle t has its grant visible at t+1, so `s_arvalid` can rise at t+1.
- Release at handshake cycle t: FSM is IDLE at t+1, next grant at t+2. This gives a one-cycle bubble between bursts.
- R and B paths are purely combinational through the mux. There are no added data registers, so R beat latency is 0 cycles.
- A burst of `arlen`+1 beats holds the grant for all beats. Back-pressure via `m_rready` stalls without releasing.
- A requester dropping `arvalid` before the handshake while granted is an AXI violation. Behaviour is undefined and flagged by an assertion.

## Configuration
- `YSYX_24100006_ARB_RR_EN`:
  - Defined: round-robin. A per-channel pointer records the last granted index, and the search starts at pointer+1 modulo `NUM_MASTERS`. The pointer resets to `NUM_MASTERS-1`, so index 0 wins first.
  - Undefined: fixed priority, lowest index wins (MEMU first). There is no pointer register.

## Structure
- Package `ysyx_24100006_axi_pkg`: read/write FSM state typedefs, AXI resp constants (OKAY=2'b00), and the `ARB_MAX_MASTERS`=8 constant.
- Sub-module `ysyx_24100006_arb_pick`: takes request vector, pointer and enable, and outputs a one-hot grant plus index.
  - Instantiated twice, once for read and once for write.
  - Holds the `_RR_EN` logic.

## Test plan
- Reset: hold `reset`=0 with `m_arvalid`=2'b11 -> all readies/valids 0. After release, `rd_gnt`=0 at the first active edge + 1.
- Simultaneous AR from masters 0 and 1, each `arlen`=3, with RR: master 0 gets 4 beats, then master 1 gets 4 beats. Release-to-grant gap is exactly 1 cycle. `m_rvalid[1]`=0 throughout master 0's burst.
- Fixed priority (macro undefined): master 0 requests continuously and master 1 is starved. With RR defined, grants alternate 0,1,0,1.
- Concurrent read by master 1 (IFU) and write by master 0, `awaddr`=0x8000_0010, `wstrb`=4'b1100, `wdata`=0xABCD_0000 -> slave sees the write unmodified while the read progresses. Each channel releases independently.
- `rready` held low for 5 cycles mid-burst -> grant held, `s_rready`=0, and no beat is lost.
- Reset asserted during beat 2 of a 4-beat read -> outputs 0 within the same cycle. After release, the next request is arbitrated fresh.
